dsp_mac_sequencer: RTL
======================

DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

Interface
REQ-001 SHALL have parameter PIPE_LAT, default 3: cycles from operand on dsp_a/dsp_b to product included in dsp_p.
REQ-002 SHALL have parameter OPM_DLY, default 1: cycles the dsp_opmode tag lags its operand pair.
REQ-003 SHALL have parameter LEN_W, default 16: width of the vector-length input.
REQ-004 SHALL use a single clock and an asynchronous, active-high reset; all sequential logic is clocked on the rising edge of clk.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 start  in  1  one-cycle request to begin a dot product; honoured only in IDLE.
REQ-008 len  in  LEN_W  number of operand pairs; sampled with start.
REQ-009 sub  in  1  sampled with start; 1 = subtract each product (OPMODE[7]).
REQ-010 in_valid / in_ready  in / out  1 / 1  operand handshake.
REQ-011 in_a, in_b  in  18 / 18  signed operands.
REQ-012 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-013 out_p  out  48  signed accumulated result.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 dsp_a, dsp_b  out  18 / 18  operands driven to the slice A and B ports.
REQ-016 dsp_opmode  out  8  OPMODE driven to the slice.
REQ-017 dsp_p  in  48  P from the slice.

Function
REQ-018 SHALL implement the states IDLE, ISSUE, DRAIN and DONE.
REQ-019 IDLE: start=1 with len>0 latches len and sub, then enters ISSUE; start=1 with len=0 loads out_p=0 and enters DONE; any start outside IDLE is ignored.
REQ-020 ISSUE: in_ready=1; each in_valid&in_ready cycle drives in_a/in_b onto dsp_a/dsp_b on the next edge, tags the pair valid (first=1 for pair 0) and decrements the remaining count.
REQ-021 ISSUE: a cycle without a handshake inserts a bubble tag; dsp_a/dsp_b hold their value.
REQ-022 After the last pair is accepted, SHALL set in_ready=0 and enter DRAIN.
REQ-023 Tags SHALL travel through an OPM_DLY-deep delay line, then drive dsp_opmode as follows: first -> {sub,3'b000,2'b00,2'b01} (Z=0, X=M); valid not first -> {sub,3'b000,2'b10,2'b01} (Z=P, X=M); bubble -> 8'h08 (Z=P, X=0); IDLE/DONE -> 8'h00.
REQ-024 DRAIN SHALL last exactly PIPE_LAT cycles, then sample dsp_p into out_p and enter DONE; with defaults, out_valid rises 4 cycles after the last input handshake.
REQ-025 DONE: out_valid=1 and out_p stable until out_ready=1; on that cycle go to IDLE; out_ready without out_valid has no effect.
REQ-026 Sign and width handling SHALL be performed in the slice; the sequencer neither truncates nor extends out_p (mod-2^48 wrap).
REQ-027 A simultaneous start and out_ready in DONE SHALL complete the handshake only; start is ignored.

Reset
REQ-028 rst SHALL force: state=IDLE, in_ready=0, out_valid=0, out_p=0, busy=0, dsp_a=dsp_b=0, dsp_opmode=8'h00, all tags=bubble-free zero, remaining count=0.
REQ-029 Reset asserted mid-vector SHALL abandon the operation with no out_valid; the first start after release behaves as from power-up.

Structure
REQ-030 The OPMODE encodings (Z/X select fields, the four opmode constants) and the state encoding SHALL live in a shared package, dsp_seq_pkg.
REQ-031 The tag delay line SHALL be one sub-module, seq_tag_pipe (parameter DEPTH, async active-high reset).
REQ-032 The bench SHALL instantiate the sequencer against the team's DSP48A1 slice with default parameters and B_INPUT="DIRECT".

Verification
REQ-033 len=4, sub=0, pairs (1,2),(3,4),(5,6),(7,8) back-to-back -> out_p=100, out_valid 4 cycles after the last handshake.
REQ-034 Same vector with in_valid low for 2 cycles between pairs 2 and 3 -> out_p=100; dsp_opmode=8'h08 on the bubble cycles.
REQ-035 len=2, pairs (-3,5),(2,2) -> out_p=48'hFFFF_FFFF_FFF5 (-11); len=2, sub=1, pairs (1,2),(3,4) -> out_p=-14.
REQ-036 len=0 start -> out_valid next cycle with out_p=0 and no dsp_opmode activity; with out_ready held low for 5 cycles, out_p holds and start pulses are ignored.
REQ-037 rst asserted after 2 of 4 pairs -> all outputs at reset values, no out_valid; a new len=1 run of (9,9) -> out_p=81.

Source files
------------

// File: rtl/dsp_seq_pkg.sv
// dsp_seq_pkg: shared states, tags and DSP48A1 OPMODE encodings for the MAC sequencer
package dsp_seq_pkg;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_BUBBLE, TAG_VALID, TAG_FIRST} tag_t;
    localparam logic [1:0] Z_ZERO = 2'b00;
    localparam logic [1:0] Z_P    = 2'b10;
    localparam logic [1:0] X_ZERO = 2'b00;
    localparam logic [1:0] X_M    = 2'b01;
    localparam logic [7:0] OPM_IDLE   = 8'h00;
    localparam logic [7:0] OPM_BUBBLE = {4'b0000, Z_P, X_ZERO};
    localparam logic [7:0] OPM_FIRST  = {4'b0000, Z_ZERO, X_M};
    localparam logic [7:0] OPM_ACC    = {4'b0000, Z_P, X_M};
    function automatic logic [7:0] tag_opmode(tag_t t, logic sub);
        return t == TAG_FIRST  ? {sub, OPM_FIRST[6:0]} :
               t == TAG_VALID  ? {sub, OPM_ACC[6:0]}   :
               t == TAG_BUBBLE ? OPM_BUBBLE : OPM_IDLE;
    endfunction
endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// dsp_mac_sequencer_if: request/operand/result handshakes plus the slice-facing signals
interface dsp_mac_sequencer_if #(parameter int LEN_W = 16);
    logic start;
    logic [LEN_W-1:0] len;
    logic sub;
    logic in_valid;
    logic in_ready;
    logic signed [17:0] in_a;
    logic signed [17:0] in_b;
    logic out_valid;
    logic out_ready;
    logic signed [47:0] out_p;
    logic busy;
    logic signed [17:0] dsp_a;
    logic signed [17:0] dsp_b;
    logic [7:0] dsp_opmode;
    logic signed [47:0] dsp_p;
    modport master (
        output start, len, sub, in_valid, in_a, in_b, out_ready, dsp_p,
        input  in_ready, out_valid, out_p, busy, dsp_a, dsp_b, dsp_opmode
    );
    modport slave (
        input  start, len, sub, in_valid, in_a, in_b, out_ready, dsp_p,
        output in_ready, out_valid, out_p, busy, dsp_a, dsp_b, dsp_opmode
    );
endinterface

// File: rtl/seq_tag_pipe.sv
// seq_tag_pipe: fixed-depth delay line aligning issue tags with the slice multiplier output
module seq_tag_pipe
    import dsp_seq_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  tag_t d,
    output tag_t q
);
    tag_t sr [DEPTH];
    // shift tags one stage per clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sr <= '{default: TAG_NONE};
        else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end
    assign q = sr[DEPTH-1];
endmodule

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: streams operand pairs into a DSP48A1 slice and returns the dot product
module dsp_mac_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int PIPE_LAT = 3,
    parameter int OPM_DLY  = 1,
    parameter int LEN_W    = 16
) (
    input logic clk,
    input logic rst,
    dsp_mac_sequencer_if.slave bus
);
    localparam int DW = $clog2(PIPE_LAT + 1);
    state_t state, state_n;
    tag_t tag_in, tag_q, tag_d;
    logic [LEN_W-1:0] rem;
    logic [DW-1:0] dcnt;
    logic sub_q, first_q, hs;
    assign hs = bus.in_valid && state == S_ISSUE;
    assign bus.in_ready  = state == S_ISSUE;
    assign bus.out_valid = state == S_DONE;
    assign bus.busy      = state != S_IDLE;
    // stale tags are masked whenever no vector is in flight
    assign bus.dsp_opmode = (state == S_IDLE || state == S_DONE) ? OPM_IDLE : tag_opmode(tag_d, sub_q);
    seq_tag_pipe #(.DEPTH(OPM_DLY)) u_tag_pipe (
        .clk(clk),
        .rst(rst),
        .d(tag_q),
        .q(tag_d)
    );
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else state <= state_n;
    end
    // next state and the tag entering the opmode pipeline
    always_comb begin
        state_n = state;
        tag_in  = TAG_NONE;
        case (state)
            S_IDLE: if (bus.start) state_n = bus.len != '0 ? S_ISSUE : S_DONE;
            S_ISSUE: begin
                tag_in = hs ? (first_q ? TAG_FIRST : TAG_VALID) : TAG_BUBBLE;
                if (hs && rem == LEN_W'(1)) state_n = S_DRAIN;
            end
            S_DRAIN: begin
                tag_in = TAG_BUBBLE;
                if (dcnt == '0) state_n = S_DONE;
            end
            default: if (bus.out_ready) state_n = S_IDLE;
        endcase
    end
    // operand registers, counters and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem       <= '0;
            dcnt      <= '0;
            sub_q     <= 1'b0;
            first_q   <= 1'b0;
            tag_q     <= TAG_NONE;
            bus.out_p <= '0;
            bus.dsp_a <= '0;
            bus.dsp_b <= '0;
        end else begin
            tag_q <= tag_in;
            if (state == S_IDLE && bus.start) begin
                if (bus.len != '0) begin
                    rem     <= bus.len;
                    sub_q   <= bus.sub;
                    first_q <= 1'b1;
                end else bus.out_p <= '0;
            end
            if (hs) begin
                bus.dsp_a <= bus.in_a;
                bus.dsp_b <= bus.in_b;
                rem       <= rem - 1'b1;
                first_q   <= 1'b0;
                dcnt      <= DW'(PIPE_LAT - 1);
            end
            if (state == S_DRAIN) begin
                dcnt <= dcnt - 1'b1;
                if (dcnt == '0) bus.out_p <= bus.dsp_p;
            end
        end
    end
endmodule
